// File: rtl/exp_mu_table.sv
// Capture table for the S0*exp(t*mu) generator stream, with single-word read port.
// Optional EXP_MU_TABLE_CLAMP_EN: clamp out-of-range reads in READY to the table ends.
module exp_mu_table #(
   parameter int t_min = 343,
   parameter int t_max = 511,
   parameter int logT  = 9
) (
   input  logic            CLK,
   input  logic            iRST_N,
   input  logic            iLoad,
   input  logic            iWrEn,
   input  logic [logT-1:0] iWrAddr,
   input  logic [17:0]     iWrData,
   input  logic            iWrDone,
   input  logic            iRdReq,
   input  logic [logT-1:0] iRdT,
   output logic [17:0]     oRdData,
   output logic            oRdValid,
   output logic            oRdErr,
   output logic            oReady,
   output logic            oCapErr
);

   localparam int DEPTH = t_max - t_min + 1;
   localparam int IDXW  = $clog2(DEPTH);
   localparam logic [logT:0]   T_MIN_X = (logT+1)'(t_min);
   localparam logic [logT:0]   T_MAX_X = (logT+1)'(t_max);
   localparam logic [logT-1:0] T_MIN   = logT'(t_min);
   localparam logic [7:0]      DEPTH8  = 8'(DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, READY, ERROR} state_t;

   state_t      state;
   logic [7:0]  count;
   logic [7:0]  count_nxt;
   logic [17:0] mem [DEPTH];

   logic            wr_in_range, wr_ok;
   logic            rd_lo, rd_hi;
   logic [IDXW-1:0] wr_idx, rd_idx;

   // Ranges compared one bit wider so an upper bound at the bus maximum stays a real compare.
   always_comb begin
      wr_in_range = ({1'b0, iWrAddr} >= T_MIN_X) && ({1'b0, iWrAddr} <= T_MAX_X);
      wr_ok       = (state == CAPTURE) && iWrEn && wr_in_range && !iLoad;
      wr_idx      = IDXW'(iWrAddr - T_MIN);
      rd_lo       = {1'b0, iRdT} < T_MIN_X;
      rd_hi       = {1'b0, iRdT} > T_MAX_X;
      rd_idx      = IDXW'(iRdT - T_MIN);
      count_nxt   = count;
      if (wr_ok && count != 8'hFF)
         count_nxt = count + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[wr_idx] <= iWrData;
   end

   always_ff @(posedge CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state   <= IDLE;
         count   <= '0;
         oReady  <= 1'b0;
         oCapErr <= 1'b0;
      end else if (iLoad) begin
         state   <= CAPTURE;
         count   <= '0;
         oReady  <= 1'b0;
         oCapErr <= 1'b0;
      end else if (state == CAPTURE) begin
         count <= count_nxt;
         if (iWrDone) begin
            if (count_nxt == DEPTH8) begin
               state  <= READY;
               oReady <= 1'b1;
            end else begin
               state   <= ERROR;
               oCapErr <= 1'b1;
            end
         end
      end
   end

   // Reads see the pre-load state, so a READY table still answers in an iLoad cycle.
   always_ff @(posedge CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oRdData  <= '0;
         oRdValid <= 1'b0;
         oRdErr   <= 1'b0;
      end else begin
         oRdValid <= iRdReq;
         if (!iRdReq) begin
            oRdErr <= 1'b0;
         end else if (state != READY) begin
            oRdData <= '0;
            oRdErr  <= 1'b1;
         end else if (rd_lo) begin
`ifdef EXP_MU_TABLE_CLAMP_EN
            oRdData <= mem[0];
            oRdErr  <= 1'b0;
`else
            oRdData <= '0;
            oRdErr  <= 1'b1;
`endif
         end else if (rd_hi) begin
`ifdef EXP_MU_TABLE_CLAMP_EN
            oRdData <= mem[DEPTH-1];
            oRdErr  <= 1'b0;
`else
            oRdData <= '0;
            oRdErr  <= 1'b1;
`endif
         end else begin
            oRdData <= mem[rd_idx];
            oRdErr  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exp_mu_table.sv
// Bench for exp_mu_table: directed sequences plus randomized sweeps against a
// reference model kept as a t-indexed array and a few flags.
module tb_exp_mu_table;

   localparam int TMIN = 343;
   localparam int TMAX = 511;
   localparam int DEPTH = TMAX - TMIN + 1;

   logic        CLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iLoad = 1'b0, iWrEn = 1'b0, iWrDone = 1'b0, iRdReq = 1'b0;
   logic [8:0]  iWrAddr = '0, iRdT = '0;
   logic [17:0] iWrData = '0;
   logic [17:0] oRdData;
   logic        oRdValid, oRdErr, oReady, oCapErr;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // reference model
   int  tab [0:511];
   bit  m_cap = 0, m_ready = 0, m_caperr = 0;
   int  m_cnt = 0;
   bit  e_valid = 0, e_err = 0;
   int  e_data = 0;

   exp_mu_table #(.t_min(TMIN), .t_max(TMAX), .logT(9)) dut (
      .CLK(CLK), .iRST_N(iRST_N), .iLoad(iLoad), .iWrEn(iWrEn),
      .iWrAddr(iWrAddr), .iWrData(iWrData), .iWrDone(iWrDone),
      .iRdReq(iRdReq), .iRdT(iRdT), .oRdData(oRdData), .oRdValid(oRdValid),
      .oRdErr(oRdErr), .oReady(oReady), .oCapErr(oCapErr)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("rd_valid", 32'(oRdValid), 32'(e_valid));
      check("rd_err",   32'(oRdErr),   32'(e_err));
      check("rd_data",  32'(oRdData),  32'(e_data));
      check("ready",    32'(oReady),   32'(m_ready));
      check("cap_err",  32'(oCapErr),  32'(m_caperr));
   endtask

   // Advance one clock: update the model from the current inputs, then compare.
   task automatic step();
      int t;
      t = int'(iRdT);
      if (iRdReq) begin
         e_valid = 1;
         if (!m_ready) begin
            e_data = 0; e_err = 1;
         end else if (t >= TMIN && t <= TMAX) begin
            e_data = tab[t]; e_err = 0;
         end else begin
`ifdef EXP_MU_TABLE_CLAMP_EN
            e_data = (t < TMIN) ? tab[TMIN] : tab[TMAX]; e_err = 0;
`else
            e_data = 0; e_err = 1;
`endif
         end
      end else begin
         e_valid = 0; e_err = 0;
      end
      if (iLoad) begin
         m_cap = 1; m_ready = 0; m_caperr = 0; m_cnt = 0;
      end else if (m_cap) begin
         if (iWrEn && int'(iWrAddr) >= TMIN && int'(iWrAddr) <= TMAX) begin
            tab[int'(iWrAddr)] = int'(iWrData);
            if (m_cnt < 255) m_cnt++;
         end
         if (iWrDone) begin
            m_cap = 0;
            m_ready = (m_cnt == DEPTH);
            m_caperr = !m_ready;
         end
      end
      @(posedge CLK);
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      iLoad = 0; iWrEn = 0; iWrDone = 0; iRdReq = 0;
   endtask

   task automatic read(input int t);
      iRdReq = 1; iRdT = 9'(t);
      step();
      iRdReq = 0;
   endtask

   // Directed sweep lo..hi with data t*2; done issued alone or alongside the last write.
   task automatic sweep(input int lo, input int hi, input bit done_with_last);
      iLoad = 1; step(); iLoad = 0;
      for (int t = lo; t <= hi; t++) begin
         iWrEn = 1; iWrAddr = 9'(t); iWrData = 18'(t * 2);
         if (done_with_last && t == hi) iWrDone = 1;
         step();
      end
      clear_inputs();
      if (!done_with_last) begin
         iWrDone = 1; step(); iWrDone = 0;
      end
   endtask

   // Randomized sweep: skips, duplicates, stray addresses, random reads and loads.
   task automatic rand_sweep();
      iLoad = 1; step(); iLoad = 0;
      for (int t = TMIN; t <= TMAX; t++) begin
         iRdReq = ($urandom_range(0, 2) == 0);
         iRdT = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(340, 511));
         iWrEn = ($urandom_range(0, 99) != 0);
         iWrAddr = ($urandom_range(0, 199) == 0) ? 9'($urandom_range(0, 342)) : 9'(t);
         iWrData = 18'($urandom);
         iWrDone = (t == TMAX) && ($urandom_range(0, 1) == 1);
         iLoad = ($urandom_range(0, 999) == 0);
         step();
         iLoad = 0;
         if ($urandom_range(0, 199) == 0) begin
            iWrEn = 1; iWrAddr = 9'($urandom_range(TMIN, TMAX)); iWrData = 18'($urandom);
            step();
         end
      end
      clear_inputs();
      iWrDone = 1; step(); iWrDone = 0;
      for (int k = 0; k < 12; k++) begin
         iRdReq = $urandom_range(0, 1) == 1;
         iRdT = 9'($urandom_range(330, 511));
         iWrEn = $urandom_range(0, 1) == 1;
         iWrAddr = 9'($urandom_range(TMIN, TMAX));
         iWrData = 18'($urandom);
         iWrDone = $urandom_range(0, 5) == 0;
         step();
      end
      clear_inputs();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) tab[i] = 0;
      repeat (2) @(posedge CLK);
      #1;
      check_outputs();
      iRST_N = 1;
      step();

      read(400);                       // IDLE read: error
      sweep(TMIN, TMAX, 0);
      check("full_ready", 32'(oReady), 32'd1);
      read(343);
      check("rd_343", 32'(oRdData), 32'd686);
      read(511);
      check("rd_511", 32'(oRdData), 32'd1022);
      read(342);
      read(0);
      for (int t = 343; t <= 347; t++) begin
         iRdReq = 1; iRdT = 9'(t); step();
      end
      iRdReq = 0; step();

      // read in the same cycle as iLoad still sees READY
      iLoad = 1; iRdReq = 1; iRdT = 9'd400; step();
      clear_inputs();
      check("load_rd_data", 32'(oRdData), 32'd800);

      iWrDone = 1; step(); iWrDone = 0;   // abort the pending capture -> ERROR
      sweep(TMIN, TMAX - 1, 0);
      check("short_caperr", 32'(oCapErr), 32'd1);
      read(400);

      sweep(TMIN, TMAX, 1);
      check("same_cycle_ready", 32'(oReady), 32'd1);

      // iLoad alongside iWrDone: stays capturing
      iLoad = 1; iWrDone = 1; step(); clear_inputs();
      check("load_done_ready", 32'(oReady), 32'd0);
      iWrEn = 1; iWrAddr = 9'd343; iWrData = 18'd5; step(); clear_inputs();
      iWrDone = 1; step(); iWrDone = 0;

      // reset mid-capture
      iLoad = 1; step(); iLoad = 0;
      for (int t = TMIN; t < TMIN + 50; t++) begin
         iWrEn = 1; iWrAddr = 9'(t); iWrData = 18'(t * 2);
         iRdReq = 1; iRdT = 9'(t);
         step();
      end
      clear_inputs();
      iRST_N = 0;
      #1;
      m_cap = 0; m_ready = 0; m_caperr = 0; m_cnt = 0;
      e_valid = 0; e_err = 0; e_data = 0;
      check_outputs();
      @(posedge CLK); #1;
      iRST_N = 1;
      read(400);
      check("post_rst_err", 32'(oRdErr), 32'd1);

      sweep(TMIN, TMAX, 0);
      repeat (20) rand_sweep();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
